// File: rtl/demux_4x_nbit.sv
// Registered 1-to-4 demultiplexer: each of four channels holds one word until its consumer takes it.
// Build macro DEMUX_ROUND_ROBIN_EN: the target channel comes from an internal rotating pointer instead of in_sel.
module demux_4x_nbit #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] out_a,
  output logic [BUS_WIDTH-1:0] out_b,
  output logic [BUS_WIDTH-1:0] out_c,
  output logic [BUS_WIDTH-1:0] out_d,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic                 busy
);

  logic [1:0]           tgt;
  logic                 accept;
  logic [BUS_WIDTH-1:0] data_q [4];
  logic [BUS_WIDTH-1:0] data_d [4];
  logic [3:0]           valid_q;
  logic [3:0]           valid_d;
  logic [3:0]           load;
  logic [3:0]           drain;

`ifdef DEMUX_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q;
  logic [1:0] rr_ptr_d;
  logic       unused_sel;

  assign unused_sel = ^in_sel;
  assign tgt        = rr_ptr_q;

  // Pointer advances only on an accepted word, so a full target stalls everything.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = rr_ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 2'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign tgt = in_sel;
`endif

  // A full target can still accept when its consumer drains in the same cycle.
  assign in_ready = ~valid_q[tgt] | out_ready[tgt];
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      assign load[gi]    = accept & (tgt == 2'(gi));
      assign drain[gi]   = valid_q[gi] & out_ready[gi];
      assign valid_d[gi] = load[gi] | (valid_q[gi] & ~drain[gi]);
      assign data_d[gi]  = load[gi] ? in_data : data_q[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q[gi] <= '0;
        end else begin
          data_q[gi] <= data_d[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign out_a     = data_q[0];
  assign out_b     = data_q[1];
  assign out_c     = data_q[2];
  assign out_d     = data_q[3];
  assign out_valid = valid_q;
  assign busy      = |valid_q;

endmodule

// File: tb/tb_demux_4x_nbit.sv
// Bench for demux_4x_nbit: directed scenarios plus constrained-random traffic checked against a per-channel model.
module tb_demux_4x_nbit;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_a, out_b, out_c, out_d;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one slot per channel plus the rotating pointer.
  logic [7:0] m_data [4];
  bit         m_valid[4];
  int         m_rr;

  demux_4x_nbit #(.BUS_WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_c    (out_c),
    .out_d    (out_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dut_data(input int i);
    case (i)
      0:       return out_a;
      1:       return out_b;
      2:       return out_c;
      default: return out_d;
    endcase
  endfunction

  function automatic int model_tgt(input logic [1:0] sel);
`ifdef DEMUX_ROUND_ROBIN_EN
    return m_rr;
`else
    return int'(sel);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_data[i]  = 8'h00;
      m_valid[i] = 1'b0;
    end
    m_rr = 0;
  endtask

  task automatic check_state(input string tag);
    logic [3:0] ev;
    ev = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ev[i] = m_valid[i];
      check_eq($sformatf("%s data%0d", tag, i), {24'h0, dut_data(i)}, {24'h0, m_data[i]});
    end
    check_eq({tag, " out_valid"}, {28'h0, out_valid}, {28'h0, ev});
    check_eq({tag, " busy"}, {31'h0, busy}, {31'h0, |ev});
  endtask

  // Drive one cycle from just after a falling edge; returns whether the word was accepted.
  task automatic cycle(input bit iv, input logic [1:0] is, input logic [7:0] id,
                       input logic [3:0] ordy, output bit acc);
    int t;
    bit exp_rdy;
    in_valid  = iv;
    in_sel    = is;
    in_data   = id;
    out_ready = ordy;
    #1;
    check_state("pre");
    t       = model_tgt(is);
    exp_rdy = !m_valid[t] || ordy[t];
    check_eq("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
    acc = iv && exp_rdy;
    $display("[TB] t=%0t valid=%0b sel=%0d data=%02h out_ready=%04b tgt=%0d accept=%0b",
             $time, iv, is, id, ordy, t, acc);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && ordy[i]) m_valid[i] = 1'b0;
    end
    if (acc) begin
      m_data[t]  = id;
      m_valid[t] = 1'b1;
      m_rr       = (m_rr + 1) % 4;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    rst_n     = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit         acc;
    bit         pend;
    logic [1:0] p_sel;
    logic [7:0] p_data;

    in_data   = 8'h00;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    rst_n     = 1'b0;
    model_reset();
    #2;
    check_state("reset");
    check_eq("reset in_ready", {31'h0, in_ready}, 32'h1);
    do_reset();

`ifdef DEMUX_ROUND_ROBIN_EN
    // Round-robin: in_sel held at 3 but words rotate across channels.
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 2'd3, 8'(8'h10 + k), 4'b1111, acc);
      check_eq("rr accept", {31'h0, acc}, 32'h1);
    end
    cycle(1'b0, 2'd3, 8'h00, 4'b0000, acc);
    check_eq("rr out_a", {24'h0, out_a}, 32'h14);
    check_eq("rr out_b", {24'h0, out_b}, 32'h15);
    check_eq("rr out_c", {24'h0, out_c}, 32'h12);
    check_eq("rr out_d", {24'h0, out_d}, 32'h13);
    check_eq("rr_ptr", {30'h0, dut.rr_ptr_q}, 32'd2);
    do_reset();
`endif

    // Single word to channel 2.
    cycle(1'b1, 2'd2, 8'hA5, 4'b0000, acc);
    cycle(1'b0, 2'd0, 8'h00, 4'b0000, acc);
`ifndef DEMUX_ROUND_ROBIN_EN
    check_eq("first out_c", {24'h0, out_c}, 32'hA5);
    check_eq("first out_valid", {28'h0, out_valid}, 32'h4);
`endif
    do_reset();

    // Fill channel 1, then stall on it, then load and drain together.
    cycle(1'b1, 2'd1, 8'h5A, 4'b0000, acc);
    for (int k = 0; k < 5; k++) cycle(1'b1, 2'd1, 8'hC3, 4'b0000, acc);
    cycle(1'b1, 2'd1, 8'hC3, 4'b0010, acc);
    cycle(1'b0, 2'd1, 8'h00, 4'b0000, acc);
    do_reset();

    // Fill all four back-to-back, stall a fifth, drain all at once.
    for (int k = 0; k < 4; k++) cycle(1'b1, 2'(k), 8'(k + 1), 4'b0000, acc);
    cycle(1'b1, 2'($urandom_range(0, 3)), 8'hEE, 4'b0000, acc);
    check_eq("fifth stalled", {31'h0, acc}, 32'h0);
    cycle(1'b0, 2'd0, 8'h00, 4'b1111, acc);
    cycle(1'b0, 2'd0, 8'h00, 4'b0000, acc);
    check_eq("drain out_d kept", {24'h0, out_d}, 32'h04);

    // Asynchronous reset mid-cycle with channels 1 and 3 full.
    do_reset();
    cycle(1'b1, 2'd1, 8'h11, 4'b0000, acc);
    cycle(1'b1, 2'd3, 8'h33, 4'b0000, acc);
    in_valid = 1'b0;
    #1;
`ifndef DEMUX_ROUND_ROBIN_EN
    check_eq("pre-reset out_valid", {28'h0, out_valid}, 32'ha);
`endif
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_state("async reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic; a pending word is held stable until accepted.
    pend   = 1'b0;
    p_sel  = 2'd0;
    p_data = 8'h00;
    for (int k = 0; k < 400; k++) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend   = 1'b1;
        p_sel  = 2'($urandom_range(0, 3));
        p_data = 8'($urandom);
      end
      cycle(pend, p_sel, p_data, 4'($urandom_range(0, 15)), acc);
      if (acc) pend = 1'b0;
    end
    in_valid = 1'b0;
    #1;
    check_state("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
